// File: rtl/soc_system_pio_pkg.sv
// Shared definitions for the soc_system PIO slaves: register addresses and edge-type encodings.
// Latency: n/a (constants and a pure combinational helper).
// Backpressure: n/a.
package soc_system_pio_pkg;

   // Register window word addresses
   localparam logic [1:0] PIO_ADDR_DATA    = 2'd0;
   localparam logic [1:0] PIO_ADDR_IRQMASK = 2'd1;
   localparam logic [1:0] PIO_ADDR_RSVD    = 2'd2;
   localparam logic [1:0] PIO_ADDR_EDGECAP = 2'd3;

   // Edge that sets a capture bit
   localparam int EDGE_RISE = 0;
   localparam int EDGE_FALL = 1;
   localparam int EDGE_ANY  = 2;

   // Per-bit edge strobe from the current and previous filtered value
   function automatic logic [31:0] pio_edge(input logic [31:0] cur,
                                            input logic [31:0] prv,
                                            input int          edge_type);
      logic [31:0] res;
      case (edge_type)
         EDGE_FALL: res = ~cur & prv;
         EDGE_ANY:  res = cur ^ prv;
         default:   res = cur & ~prv;
      endcase
      return res;
   endfunction

endpackage

// File: rtl/soc_system_pio_debounce.sv
// One-bit debounce filter: output toggles only after the input has disagreed with it for DEBOUNCE_CYCLES cycles.
// Latency: DEBOUNCE_CYCLES+1 cycles from a stable input change to the output; 1 cycle while load is high.
// Backpressure: none; free-running per-cycle filter.
module soc_system_pio_debounce #(
   parameter int DEBOUNCE_CYCLES = 16
)(
   input  logic clk,
   input  logic reset_n,
   input  logic load,
   input  logic din,
   output logic dout
);

   logic [15:0] cnt;

   // Count consecutive disagreement cycles; load tracks the input directly during warm-up
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt  <= '0;
         dout <= 1'b0;
      end else if (load) begin
         cnt  <= '0;
         dout <= din;
      end else if (din == dout) begin
         cnt  <= '0;
      end else if (cnt == 16'(DEBOUNCE_CYCLES)) begin
         cnt  <= '0;
         dout <= ~dout;
      end else begin
         cnt  <= cnt + 16'd1;
      end
   end

endmodule

// File: rtl/soc_system_status_in.sv
// Avalon-MM input PIO: synchronises status lines, captures edges per bit, maskable level irq. Option: SOC_SYSTEM_STATUS_IN_DEBOUNCE_EN.
// Latency: in_port to DATA in SYNC_STAGES+1 cycles (+DEBOUNCE_CYCLES with debounce); edge to irq one cycle later.
// Backpressure: none; zero-wait-state reads, writes always accepted.
module soc_system_status_in
   import soc_system_pio_pkg::*;
#(
   parameter int WIDTH           = 32,
   parameter int SYNC_STAGES     = 2,
   parameter int EDGE_TYPE       = 0,
   parameter int DEBOUNCE_CYCLES = 16
)(
   input  logic             clk,
   input  logic             reset_n,
   input  logic [1:0]       address,
   input  logic             chipselect,
   input  logic             write_n,
   input  logic [31:0]      writedata,
   input  logic [WIDTH-1:0] in_port,
   output logic [31:0]      readdata,
   output logic             irq
);

   // Elaboration-time parameter range checks
   if (WIDTH == 0 || WIDTH > 32) begin : g_bad_width
      $error("soc_system_status_in: WIDTH must be 1..32");
   end
   if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
      $error("soc_system_status_in: SYNC_STAGES must be 2..4");
   end
   if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > 65535) begin : g_bad_db
      $error("soc_system_status_in: DEBOUNCE_CYCLES must be 1..65535");
   end

   // Warm-up runs SYNC_STAGES+1 cycles; arming lands one edge later so the
   // power-up level change already seen by prev can never be captured.
   localparam logic [2:0] WU_LAST = 3'(SYNC_STAGES + 1);

   logic [WIDTH-1:0] sync_q [SYNC_STAGES];
   logic [WIDTH-1:0] filt;
   logic [WIDTH-1:0] prev;
   logic [WIDTH-1:0] irq_mask;
   logic [WIDTH-1:0] edge_cap;
   logic [WIDTH-1:0] edge_det;
   logic [WIDTH-1:0] cap_clr;
   logic [31:0]      edge_all;
   logic [2:0]       wu_cnt;
   logic             armed;
   logic             wr_en;

   assign wr_en = chipselect && !write_n;

   // Synchroniser chain for the asynchronous status lines
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      end else begin
         sync_q[0] <= in_port;
         for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      end
   end

`ifdef SOC_SYSTEM_STATUS_IN_DEBOUNCE_EN
   // Per-bit debounce; filters are preloaded from the synchroniser until armed
   for (genvar b = 0; b < WIDTH; b++) begin : g_db
      soc_system_pio_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
         .clk     (clk),
         .reset_n (reset_n),
         .load    (!armed),
         .din     (sync_q[SYNC_STAGES-1][b]),
         .dout    (filt[b])
      );
   end
`else
   // Pass-through filter: register the last synchroniser stage
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) filt <= '0;
      else          filt <= sync_q[SYNC_STAGES-1];
   end
`endif

   // Previous filtered value for edge detection
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) prev <= '0;
      else          prev <= filt;
   end

   // Warm-up counter and arm flag after reset release
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wu_cnt <= '0;
         armed  <= 1'b0;
      end else if (!armed) begin
         if (wu_cnt == WU_LAST) armed  <= 1'b1;
         else                   wu_cnt <= wu_cnt + 3'd1;
      end
   end

   // Edge strobe and write-one-to-clear vector
   always_comb begin
      edge_all = pio_edge(32'(filt), 32'(prev), EDGE_TYPE);
      edge_det = edge_all[WIDTH-1:0];
      cap_clr  = '0;
      if (wr_en && address == PIO_ADDR_EDGECAP) cap_clr = writedata[WIDTH-1:0];
   end

   // Edge capture: a new edge overrides a clear of the same bit
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) edge_cap <= '0;
      else          edge_cap <= (edge_cap & ~cap_clr) | (armed ? edge_det : '0);
   end

   // Interrupt mask register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)                                   irq_mask <= '0;
      else if (wr_en && address == PIO_ADDR_IRQMASK)  irq_mask <= writedata[WIDTH-1:0];
   end

   assign irq = |(edge_cap & irq_mask);

   // Zero-wait read mux; unused upper bits read 0
   always_comb begin
      readdata = '0;
      case (address)
         PIO_ADDR_DATA:    readdata[WIDTH-1:0] = filt;
         PIO_ADDR_IRQMASK: readdata[WIDTH-1:0] = irq_mask;
         PIO_ADDR_EDGECAP: readdata[WIDTH-1:0] = edge_cap;
         default:          readdata = '0;
      endcase
   end

endmodule

// File: tb/tb_soc_system_status_in.sv
// Self-checking bench for soc_system_status_in: directed vector table plus hand-written multi-cycle sequences.
// Latency: n/a.
// Backpressure: n/a.
module tb_soc_system_status_in;

   localparam int S = 2;
`ifdef SOC_SYSTEM_STATUS_IN_DEBOUNCE_EN
   localparam int D = 16;
   localparam int LAT = S + 1 + D;
`else
   localparam int LAT = S + 1;
`endif
   localparam int SETTLE = LAT + 4;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [1:0]  address;
   logic        chipselect;
   logic        write_n;
   logic [31:0] writedata;
   logic [31:0] in_port;
   logic [31:0] readdata;
   logic        irq;

   int n_cmp = 0;
   int n_bad = 0;

   soc_system_status_in dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .address    (address),
      .chipselect (chipselect),
      .write_n    (write_n),
      .writedata  (writedata),
      .in_port    (in_port),
      .readdata   (readdata),
      .irq        (irq)
   );

   always #5 clk = ~clk;

   typedef struct {
      string       name;
      logic [31:0] in_val;
      bit          bus;
      bit          cs;
      bit          wn;
      logic [1:0]  addr;
      logic [31:0] wdata;
      int          cycles;
      logic [1:0]  rd_addr;
      logic [31:0] exp_rd;
      logic        exp_irq;
   } vec_t;

   vec_t tv [14];

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic bus(input logic c, input logic w, input logic [1:0] a, input logic [31:0] d);
      chipselect = c;
      write_n    = w;
      address    = a;
      writedata  = d;
      @(posedge clk);
      #1;
      chipselect = 1'b0;
      write_n    = 1'b1;
   endtask

   task automatic rd_chk(input string nm, input logic [1:0] a, input logic [31:0] exp);
      address = a;
      #1;
      check(nm, readdata, exp);
   endtask

   task automatic irq_chk(input string nm, input logic exp);
      #1;
      check(nm, {31'b0, irq}, {31'b0, exp});
   endtask

   initial begin
      reset_n    = 1'b0;
      in_port    = 32'hFFFF_FFFF;
      chipselect = 1'b0;
      write_n    = 1'b1;
      address    = 2'd0;
      writedata  = '0;

      // Reset state with all inputs high
      tick(3);
      rd_chk("rst_data", 2'd0, 32'h0);
      rd_chk("rst_cap", 2'd3, 32'h0);
      irq_chk("rst_irq", 1'b0);

      // Release and watch warm-up: the power-up level must not be captured
      reset_n = 1'b1;
      for (int i = 0; i < LAT + 3; i++) begin
         tick(1);
         rd_chk("warm_cap", 2'd3, 32'h0);
      end
      rd_chk("warm_data", 2'd0, 32'hFFFF_FFFF);
      irq_chk("warm_irq", 1'b0);

      // Falling edges are ignored for rising-edge capture
      in_port = 32'h0;
      tick(SETTLE);
      rd_chk("fall_data", 2'd0, 32'h0);
      rd_chk("fall_cap", 2'd3, 32'h0);

      // Bit 5 rising edge: capture and irq exactly LAT+1 edges after the input change
      bus(1'b1, 1'b0, 2'd1, 32'h20);
      in_port = 32'h20;
      tick(LAT);
      rd_chk("b5_cap_early", 2'd3, 32'h0);
      irq_chk("b5_irq_early", 1'b0);
      tick(1);
      rd_chk("b5_cap", 2'd3, 32'h20);
      irq_chk("b5_irq", 1'b1);
      bus(1'b1, 1'b0, 2'd3, 32'h20);
      rd_chk("b5_cap_clr", 2'd3, 32'h0);
      irq_chk("b5_irq_clr", 1'b0);

      // Register-level vector table
      tv[0]  = '{"mask_clr",    32'h20, 1'b1, 1'b1, 1'b0, 2'd1, 32'h0,         0,      2'd1, 32'h0,  1'b0};
      tv[1]  = '{"in_low",      32'h00, 1'b0, 1'b0, 1'b1, 2'd0, 32'h0,         SETTLE, 2'd0, 32'h0,  1'b0};
      tv[2]  = '{"cap_no_fall", 32'h00, 1'b0, 1'b0, 1'b1, 2'd0, 32'h0,         0,      2'd3, 32'h0,  1'b0};
      tv[3]  = '{"in_ff",       32'hFF, 1'b0, 1'b0, 1'b1, 2'd0, 32'h0,         SETTLE, 2'd0, 32'hFF, 1'b0};
      tv[4]  = '{"cap_ff",      32'hFF, 1'b0, 1'b0, 1'b1, 2'd0, 32'h0,         0,      2'd3, 32'hFF, 1'b0};
      tv[5]  = '{"mask_80",     32'hFF, 1'b1, 1'b1, 1'b0, 2'd1, 32'h80,        0,      2'd1, 32'h80, 1'b1};
      tv[6]  = '{"rsvd_wr",     32'hFF, 1'b1, 1'b1, 1'b0, 2'd2, 32'hDEADBEEF,  0,      2'd2, 32'h0,  1'b1};
      tv[7]  = '{"w1c_low4",    32'hFF, 1'b1, 1'b1, 1'b0, 2'd3, 32'h0F,        0,      2'd3, 32'hF0, 1'b1};
      tv[8]  = '{"w1c_bit7",    32'hFF, 1'b1, 1'b1, 1'b0, 2'd3, 32'h80,        0,      2'd3, 32'h70, 1'b0};
      tv[9]  = '{"mask_10",     32'hFF, 1'b1, 1'b1, 1'b0, 2'd1, 32'h10,        0,      2'd1, 32'h10, 1'b1};
      tv[10] = '{"w1c_all",     32'hFF, 1'b1, 1'b1, 1'b0, 2'd3, 32'hFFFFFFFF,  0,      2'd3, 32'h0,  1'b0};
      tv[11] = '{"data_hold",   32'hFF, 1'b0, 1'b0, 1'b1, 2'd0, 32'h0,         3,      2'd0, 32'hFF, 1'b0};
      tv[12] = '{"wr_no_cs",    32'hFF, 1'b1, 1'b0, 1'b0, 2'd1, 32'hFFFF,      0,      2'd1, 32'h10, 1'b0};
      tv[13] = '{"wr_wn_high",  32'hFF, 1'b1, 1'b1, 1'b1, 2'd1, 32'hFFFF,      0,      2'd1, 32'h10, 1'b0};

      for (int k = 0; k < 14; k++) begin
         in_port = tv[k].in_val;
         if (tv[k].bus) bus(tv[k].cs, tv[k].wn, tv[k].addr, tv[k].wdata);
         tick(tv[k].cycles);
         rd_chk(tv[k].name, tv[k].rd_addr, tv[k].exp_rd);
         irq_chk({tv[k].name, "_irq"}, tv[k].exp_irq);
      end

      // Clear of bit 3 in the same cycle a bit-3 edge is captured: set wins
      in_port = 32'hF7;
      tick(SETTLE);
      in_port = 32'hFF;
      tick(LAT);
      rd_chk("coll_pre", 2'd3, 32'h0);
      bus(1'b1, 1'b0, 2'd3, 32'h08);
      rd_chk("coll_set_wins", 2'd3, 32'h08);
      bus(1'b1, 1'b0, 2'd3, 32'h08);
      rd_chk("coll_later_clr", 2'd3, 32'h0);

      // Mid-operation reset with EDGECAP = 0xF
      in_port = 32'hF0;
      tick(SETTLE);
      in_port = 32'hFF;
      tick(SETTLE);
      rd_chk("pre_rst_cap", 2'd3, 32'h0F);
      bus(1'b1, 1'b0, 2'd1, 32'h01);
      irq_chk("pre_rst_irq", 1'b1);
      reset_n = 1'b0;
      rd_chk("mid_rst_cap", 2'd3, 32'h0);
      rd_chk("mid_rst_mask", 2'd1, 32'h0);
      rd_chk("mid_rst_data", 2'd0, 32'h0);
      irq_chk("mid_rst_irq", 1'b0);
      tick(2);
      reset_n = 1'b1;
      for (int i = 0; i < LAT + 3; i++) begin
         tick(1);
         rd_chk("rewarm_cap", 2'd3, 32'h0);
      end
      rd_chk("rewarm_data", 2'd0, 32'hFF);
      irq_chk("rewarm_irq", 1'b0);

`ifdef SOC_SYSTEM_STATUS_IN_DEBOUNCE_EN
      // Debounce: short pulse rejected, long pulse captured
      in_port = 32'hFE;
      tick(LAT + 10);
      bus(1'b1, 1'b0, 2'd3, 32'hFFFFFFFF);
      in_port = 32'hFF;
      tick(10);
      in_port = 32'hFE;
      tick(LAT + 10);
      rd_chk("db_short_data", 2'd0, 32'hFE);
      rd_chk("db_short_cap", 2'd3, 32'h0);
      in_port = 32'hFF;
      tick(20);
      in_port = 32'hFE;
      tick(LAT + 10);
      rd_chk("db_long_cap", 2'd3, 32'h01);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/soc_system_status_in.md
# soc_system_status_in

Avalon-MM input PIO slave: the read-side counterpart of the control output ports in `soc_system`. It samples up to 32 external status lines (IGBT driver fault/ready flags) into the `clk` domain and captures edges per bit. It raises a maskable interrupt to the HPS and exposes everything through a 4-word register window on the lightweight HPS-to-FPGA bridge.

## Interface
Parameters:
- `WIDTH`, 32: number of status inputs (1..32); unused `readdata` bits read 0.
- `SYNC_STAGES`, 2: synchronizer flops per input (2..4).
- `EDGE_TYPE`, 0: edge that sets capture. 0 = rising, 1 = falling, 2 = any.
- `DEBOUNCE_CYCLES`, 16: stable cycles required before a filtered bit changes (1..65535). Used only under `SOC_SYSTEM_STATUS_IN_DEBOUNCE_EN`.

Ports:
- `clk` in 1: single clock for all logic.
- `reset_n` in 1: reset, asynchronous assert, active-low.
- `address` in 2: word address.
- `chipselect` in 1: slave select.
- `write_n` in 1: active-low write strobe.
- `writedata` in 32: write data.
- `in_port` in WIDTH: asynchronous status inputs.
- `readdata` out 32: read data, combinational from `address`.
- `irq` out 1: level interrupt, active-high.

## Operation
- Register map:
  - 0 DATA (RO): filtered input value.
  - 1 IRQMASK (RW, bits WIDTH-1:0).
  - 2 reserved: reads 0, writes ignored.
  - 3 EDGECAP (R/W1C).
- A write is `chipselect && !write_n`. Reads have no side effects.
- Input path: `in_port` → SYNC_STAGES-flop chain → filter (debounce or pass-through) → `filt`.
- Edge detect: `prev <= filt` every cycle. The per-bit edge is `filt & ~prev` (rising), `~filt & prev` (falling), or `filt ^ prev` (any).
- Edge capture: a bit sets on a detected edge while `armed`. It clears when a write to address 3 has a 1 in that bit.
- Set/clear collision on the same bit in the same cycle: set wins and the bit stays 1.
- Warm-up: a counter of SYNC_STAGES+1 cycles runs after reset release, and `armed` goes to 1 when it expires.
  - While not armed, edges are ignored. Power-up levels therefore never produce spurious captures.
- `irq = |(EDGECAP & IRQMASK)`, decoded from registers and glitch-free.
- Reset values:
  - Sync flops, `filt`, `prev`, IRQMASK, EDGECAP, warm-up counter, `armed`, and debounce counters all 0.
  - `irq` = 0.
  - `readdata` = 0 for address 0.
- A `reset_n` assertion mid-operation clears all state immediately and restarts warm-up; pending edges are lost.

## Timing
- `in_port` change → DATA reflects it after SYNC_STAGES+1 rising edges without debounce. With debounce, add DEBOUNCE_CYCLES.
- `filt` change → EDGECAP bit set on the next edge → `irq` high in that same cycle (combinational from registers).
- IRQMASK or EDGECAP write → `irq` updates the cycle after the write edge.
- Glitches shorter than one `clk` period may be missed; this is acceptable.
- Reads are zero-wait-state: `readdata` is valid in the same cycle as `address`.

## Configuration
- `SOC_SYSTEM_STATUS_IN_DEBOUNCE_EN` defined: each bit gets a counter.
  - The counter increments while the synchronized bit ≠ `filt` and resets to 0 when they are equal.
  - When it reaches DEBOUNCE_CYCLES, `filt` toggles and the counter returns to 0.
  - Pulses shorter than DEBOUNCE_CYCLES never reach DATA or EDGECAP.
- Undefined: `filt` = last synchronizer stage, and no counters are synthesized.

## Structure
- Shared package `soc_system_pio_pkg`:
  - Address constants `PIO_ADDR_DATA`/`IRQMASK`/`EDGECAP`.
  - `EDGE_RISE`/`EDGE_FALL`/`EDGE_ANY` encodings.
- Sub-module `soc_system_pio_debounce`: one bit, parameter DEBOUNCE_CYCLES. Instantiated WIDTH times by generate, only under the macro.
- Synchronizer, edge logic, registers and the read mux are kept inline.

## Test plan
- Reset with `in_port`=32'hFFFF_FFFF held → after warm-up, DATA=32'hFFFF_FFFF, EDGECAP=0, `irq`=0.
- Rising edge on bit 5, IRQMASK=32'h20 (EDGE_TYPE=0) → EDGECAP=32'h20 and `irq`=1 exactly SYNC_STAGES+2 cycles after the edge. Writing 32'h20 to address 3 then gives EDGECAP=0 and `irq`=0 the next cycle.
- Write 1 to EDGECAP bit 3 in the same cycle a new bit-3 edge is detected → bit 3 remains 1.
- IRQMASK=0 with edges on bits 0..7 → EDGECAP=32'hFF, `irq`=0. Writing IRQMASK=32'h80 then gives `irq`=1 the next cycle.
- With macro and DEBOUNCE_CYCLES=16: a 10-cycle pulse on bit 0 leaves DATA and EDGECAP unchanged; a 20-cycle pulse sets EDGECAP bit 0.
- Assert `reset_n` while EDGECAP=32'hF, then release → all registers 0, and no capture during the SYNC_STAGES+1 warm-up cycles.
